// File: rtl/bloc_afisare_pkg.sv
// Shared constants for the bloc_afisare display driver: active-low segment
// patterns, anode mask, digit-index type and time-word field positions.
package bloc_afisare_pkg;

  // Patterns are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  localparam int PM_BIT  = 24;
  localparam int HT_LSB  = 20;
  localparam int HU_LSB  = 16;
  localparam int MT_LSB  = 12;
  localparam int MU_LSB  = 8;
  localparam int FIELD_W = 4;

  function automatic logic [3:0] an_select(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bloc_afisare_decodor_bcd_7seg.sv
// Combinational BCD to seven-segment decoder, active-low outputs.
// Codes 10-15 cannot be valid BCD and are shown as a dash.
module decodor_bcd_7seg
  import bloc_afisare_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bloc_afisare.sv
// Multiplexed 4-digit HH.MM display driver with per-frame tear-free snapshot.
// Optional field blinking is built when BLOC_AFISARE_BLINK_EN is defined.
module bloc_afisare
  import bloc_afisare_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 250
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [24:0] data_in,
  input  logic        set_minute,
  input  logic        set_ore,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned PW = $clog2(SCAN_DIV);

  logic [PW-1:0] presc_q;
  logic          tick;
  logic          pre_tick;
  digit_idx_t    idx_q, idx_d;
  logic [24:8]   shadow_q, shadow_d;
  logic [3:0]    an_q, an_nxt;
  logic [6:0]    seg_q, seg_nxt, seg_dec;
  logic          dp_q, dp_nxt;
  logic [3:0]    digit;
  logic          blank_min;
  logic          blank_hr;
  logic          unused_bits;

  assign tick     = (presc_q == PW'(SCAN_DIV - 1));
  assign pre_tick = (presc_q == PW'(SCAN_DIV - 2));

  // The snapshot is taken only when the scan wraps, so a frame never mixes two times.
  always_comb begin
    idx_d    = tick ? digit_idx_t'(idx_q + 2'd1) : idx_q;
    shadow_d = (tick && idx_q == 2'd3) ? data_in[24:8] : shadow_q;
  end

  always_comb begin
    digit = shadow_d[MU_LSB +: FIELD_W];
    case (idx_d)
      2'd0:    digit = shadow_d[MU_LSB +: FIELD_W];
      2'd1:    digit = shadow_d[MT_LSB +: FIELD_W];
      2'd2:    digit = shadow_d[HU_LSB +: FIELD_W];
      default: digit = shadow_d[HT_LSB +: FIELD_W];
    endcase
  end

  decodor_bcd_7seg u_decodor (
    .bcd_i (digit),
    .seg_o (seg_dec)
  );

`ifdef BLOC_AFISARE_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic          blink_req;

  assign blink_req = set_minute | set_ore;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!blink_req) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (tick) begin
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // Use the post-update phase so the displayed slot and phase_q always agree.
  assign blank_min   = phase_d & set_minute;
  assign blank_hr    = phase_d & set_ore;
  assign unused_bits = ^data_in[7:0];
`else
  assign blank_min   = 1'b0;
  assign blank_hr    = 1'b0;
  assign unused_bits = ^{data_in[7:0], set_minute, set_ore};
`endif

  always_comb begin
    an_nxt  = an_select(idx_d);
    seg_nxt = (idx_d == 2'd3 && digit == 4'd0) ? SEG_BLANK : seg_dec;
    dp_nxt  = ~((idx_d == 2'd2) | ((idx_d == 2'd0) & shadow_d[PM_BIT]));
    if (blank_min && !idx_d[1]) begin
      an_nxt = AN_OFF;
    end
    if (blank_hr && idx_d[1]) begin
      an_nxt = AN_OFF;
      dp_nxt = 1'b1;
    end
  end

  // Anodes go dark for the tick cycle to hide the segment change (anti-ghosting).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q  <= '0;
      idx_q    <= 2'd3;
      shadow_q <= '0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b1;
    end else begin
      presc_q  <= tick ? '0 : presc_q + 1'b1;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      if (tick) begin
        an_q  <= an_nxt;
        seg_q <= seg_nxt;
        dp_q  <= dp_nxt;
      end else if (pre_tick) begin
        an_q  <= AN_OFF;
      end
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_bloc_afisare.sv
// Self-checking bench for bloc_afisare against a time-based behavioural model.
module tb_bloc_afisare;

  localparam int SD = 4;
  localparam int BD = 2;
`ifdef BLOC_AFISARE_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [24:0] data_in;
  logic        set_minute, set_ore;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int failures = 0;

  bloc_afisare #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clock(clk), .reset(rst_n), .data_in(data_in),
    .set_minute(set_minute), .set_ore(set_ore),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000};

  // Model: edges since reset decide ticks; ticks decide slot, snapshot and blink phase.
  int          edges, ticks, blink_n, cur_idx;
  logic [24:8] shadow_m;
  logic [3:0]  slot_an, exp_an;
  logic [6:0]  slot_seg, exp_seg;
  logic        slot_dp, exp_dp;

  always @(posedge clk or negedge rst_n) begin
    logic active, phase;
    logic [3:0] d;
    if (!rst_n) begin
      edges = 0; ticks = 0; blink_n = 0; cur_idx = 3; shadow_m = '0;
      slot_an = 4'hF; slot_seg = 7'h7F; slot_dp = 1'b1;
    end else begin
      edges++;
      active = BLINK_EN && (set_minute || set_ore);
      if (edges % SD == 0) begin
        ticks++;
        cur_idx = (ticks - 1) % 4;
        if (cur_idx == 0) shadow_m = data_in[24:8];
        blink_n = active ? blink_n + 1 : 0;
        phase = ((blink_n / BD) % 2) == 1;
        d = shadow_m[8 + 4*cur_idx +: 4];
        if (cur_idx == 3 && d == 0) slot_seg = 7'h7F;
        else if (d <= 9)            slot_seg = segtab[d];
        else                        slot_seg = 7'b0111111;
        slot_an = 4'hF;
        slot_an[cur_idx] = 1'b0;
        slot_dp = !(cur_idx == 2 || (cur_idx == 0 && shadow_m[24]));
        if (phase && set_minute && cur_idx < 2) slot_an = 4'hF;
        if (phase && set_ore && cur_idx >= 2) begin slot_an = 4'hF; slot_dp = 1'b1; end
      end else if (!active) begin
        blink_n = 0;
      end
    end
    exp_an  = (edges % SD == SD - 1) ? 4'hF : slot_an;
    exp_seg = slot_seg;
    exp_dp  = slot_dp;
  end

  function automatic bit in_gap();
    return (ticks == 0) || (edges % SD == SD - 1);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; data_in = 25'h1_0945_3C; set_minute = 0; set_ore = 0;
    repeat (3) @(negedge clk);
    checks++; if (an !== 4'hF) begin failures++; $display("FAIL reset_an got=%h exp=f", an); end
    checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h exp=7f", seg); end
    checks++; if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b exp=1", dp); end
    rst_n = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      checks++; if (an !== exp_an) begin failures++; $display("FAIL first_an k=%0d got=%h exp=%h", k, an, exp_an); end
      checks++; if (seg !== exp_seg) begin failures++; $display("FAIL first_seg k=%0d got=%h exp=%h", k, seg, exp_seg); end
      checks++; if (dp !== exp_dp) begin failures++; $display("FAIL first_dp k=%0d got=%b exp=%b", k, dp, exp_dp); end
      if (k == 4) begin
        checks++; if ({an, seg, dp} !== {4'b1110, 7'b0010010, 1'b0}) begin failures++;
          $display("FAIL first_digit0 got=%h/%h/%b exp=e/12/0", an, seg, dp); end
      end
      if (k == 7) begin
        checks++; if (an !== 4'hF) begin failures++; $display("FAIL first_gap got=%h exp=f", an); end
      end
      if (k == 8) begin
        checks++; if ({an, seg, dp} !== {4'b1101, 7'b0011001, 1'b1}) begin failures++;
          $display("FAIL first_digit1 got=%h/%h/%b exp=d/19/1", an, seg, dp); end
      end
      if (k == 12) begin
        checks++; if ({an, seg, dp} !== {4'b1011, 7'b0010000, 1'b0}) begin failures++;
          $display("FAIL first_digit2 got=%h/%h/%b exp=b/10/0", an, seg, dp); end
      end
      if (k == 16) begin
        checks++; if ({an, seg, dp} !== {4'b0111, 7'b1111111, 1'b1}) begin failures++;
          $display("FAIL first_digit3 got=%h/%h/%b exp=7/7f/1", an, seg, dp); end
      end
    end
  endtask

  task automatic test_tear_free();
    int guard;
    bit seen3;
    data_in = 25'h0_1259_00;
    guard = 0;
    while (!(ticks > 0 && cur_idx == 3 && !in_gap()) && guard < 40) begin @(negedge clk); guard++; end
    guard = 0;
    while (!(cur_idx == 1 && !in_gap()) && guard < 40) begin @(negedge clk); guard++; end
    checks++; if (guard >= 40) begin failures++; $display("FAIL tear_wait timeout got=%0d exp<40", guard); end
    data_in = 25'h0_0100_00;
    seen3 = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++; if (an !== exp_an) begin failures++; $display("FAIL tear_an got=%h exp=%h", an, exp_an); end
      checks++; if (seg !== exp_seg) begin failures++; $display("FAIL tear_seg got=%h exp=%h", seg, exp_seg); end
      checks++; if (dp !== exp_dp) begin failures++; $display("FAIL tear_dp got=%b exp=%b", dp, exp_dp); end
      if (!seen3 && cur_idx == 3 && !in_gap()) begin
        seen3 = 1;
        checks++; if (seg !== 7'b1111001) begin failures++; $display("FAIL tear_old_hour got=%h exp=79", seg); end
      end
    end
  endtask

  task automatic test_dash();
    data_in = {1'b0, 4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)), 4'hB, 8'h00};
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      checks++; if (an !== exp_an) begin failures++; $display("FAIL dash_an got=%h exp=%h", an, exp_an); end
      checks++; if (seg !== exp_seg) begin failures++; $display("FAIL dash_seg got=%h exp=%h", seg, exp_seg); end
      if (ticks > 4 && cur_idx == 0 && !in_gap()) begin
        checks++; if (seg !== 7'b0111111) begin failures++; $display("FAIL dash_digit0 got=%h exp=3f", seg); end
      end
    end
  endtask

  task automatic test_blink();
    int blanked;
    blanked = 0;
    data_in = 25'h1_1134_00; set_ore = 1;
    for (int k = 0; k < 160; k++) begin
      @(negedge clk);
      checks++; if (an !== exp_an) begin failures++; $display("FAIL blink_an got=%h exp=%h", an, exp_an); end
      checks++; if (dp !== exp_dp) begin failures++; $display("FAIL blink_dp got=%b exp=%b", dp, exp_dp); end
      if (!in_gap() && an == 4'hF) blanked++;
    end
    checks++; if ((blanked > 0) !== BLINK_EN) begin failures++; $display("FAIL blink_seen got=%0d exp_any=%0d", blanked, BLINK_EN); end
    set_ore = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      checks++; if (an !== exp_an) begin failures++; $display("FAIL unblink_an got=%h exp=%h", an, exp_an); end
      checks++; if (dp !== exp_dp) begin failures++; $display("FAIL unblink_dp got=%b exp=%b", dp, exp_dp); end
    end
    blanked = 0; set_minute = 1;
    for (int k = 0; k < 96; k++) begin
      @(negedge clk);
      checks++; if (an !== exp_an) begin failures++; $display("FAIL blink_min_an got=%h exp=%h", an, exp_an); end
      if (!in_gap() && an == 4'hF) blanked++;
    end
    checks++; if ((blanked > 0) !== BLINK_EN) begin failures++; $display("FAIL blink_min_seen got=%0d exp_any=%0d", blanked, BLINK_EN); end
    set_minute = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      checks++; if (an !== exp_an) begin failures++; $display("FAIL rand_an got=%h exp=%h", an, exp_an); end
      checks++; if (seg !== exp_seg) begin failures++; $display("FAIL rand_seg got=%h exp=%h", seg, exp_seg); end
      checks++; if (dp !== exp_dp) begin failures++; $display("FAIL rand_dp got=%b exp=%b", dp, exp_dp); end
      if ($urandom_range(9) == 0) data_in = 25'($urandom);
      if ($urandom_range(29) == 0) set_minute = ~set_minute;
      if ($urandom_range(29) == 0) set_ore = ~set_ore;
    end
    set_minute = 0; set_ore = 0;
  endtask

  task automatic test_reset_mid();
    data_in = 25'h1_2222_00;
    repeat (3 + $urandom_range(5)) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin failures++;
      $display("FAIL midreset got=%h/%h/%b exp=f/7f/1", an, seg, dp); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++; if (an !== exp_an) begin failures++; $display("FAIL restart_an got=%h exp=%h", an, exp_an); end
      checks++; if (seg !== exp_seg) begin failures++; $display("FAIL restart_seg got=%h exp=%h", seg, exp_seg); end
      checks++; if (dp !== exp_dp) begin failures++; $display("FAIL restart_dp got=%b exp=%b", dp, exp_dp); end
    end
  endtask

  initial begin
    test_reset();
    test_tear_free();
    test_dash();
    test_blink();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
